axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Per-slave read-address arbiter for the AXI bridge: decodes each master's ARADDR to a target slave, grants at most one master per slave with round-robin fairness, and holds the grant until the slave's last read beat is accepted. It drives the routing indices consumed by the read-channel multiplexer (`SRIdx`, `MRIdx`), so the mux stays purely combinational and all read-path state lives here.

## Interface
- `NUM_M`, 3, number of masters; index `NUM_M` is the dummy (never-valid) master.
- `NUM_S`, 6, number of real slaves; index `NUM_S` is the default (decode-error) slave, index `NUM_S+1` is the dummy (never-ready) slave.
- `MIDX_BITS`, 2, width of a master index (≥ clog2(`NUM_M`+1)).
- `SIDX_BITS`, 3, width of a slave index (≥ clog2(`NUM_S`+2)).
- `ACLK` in 1, single clock; all logic on rising edge.
- `ARESET` in 1, synchronous, active-high reset.
- `ARADDR_M` in `NUM_M`×32, per-master read address.
- `ARVALID_M` in `NUM_M`, per-master AR valid.
- `ARREADY_S` in `NUM_S`+1, AR ready from slaves 0..`NUM_S` (the default slave included).
- `RVALID_S`, `RLAST_S` in `NUM_S`+1 each, R valid and last from each slave.
- `RREADY_M` in `NUM_M`, R ready from each master.
- `SRIdx` out `NUM_S`+1 × `MIDX_BITS`, master routed to slave s; `NUM_M` when that slave is idle.
- `MRIdx` out `NUM_M` × `SIDX_BITS`, slave routed to master m; `NUM_S+1` when that master is idle.

## Operation
- Address decode, per master, from its ARADDR:
  - S0 ROM: 0x0000_0000–0x0000_3FFF
  - S1 IM: 0x0001_0000–0x0001_FFFF
  - S2 DM: 0x0002_0000–0x0002_FFFF
  - S3 DMA: 0x1002_0000–0x1002_0400
  - S4 WDT: 0x1001_0000–0x1001_03FF
  - S5 DRAM: 0x2000_0000–0x201F_FFFF
  - Any other address goes to the default slave `NUM_S`.
- Per-slave FSM, one for each of the `NUM_S`+1 slaves including the default slave:
  - **IDLE**: arbitrate. Candidates are the masters m with `ARVALID_M[m]` high, decoding to this slave, and not busy.
  - **IDLE → ADDR**: taken when there is at least one candidate. The winner is chosen round-robin starting from `rr_ptr[s]`. The winner is latched, its master is marked busy, and `rr_ptr[s]` becomes winner+1 (mod `NUM_M`).
  - **ADDR → DATA**: taken on `ARVALID_M[g] & ARREADY_S[s]`.
  - **DATA → IDLE**: taken on `RVALID_S[s] & RREADY_M[g] & RLAST_S[s]`. The busy flag of master g clears on the same edge.
- Each master has at most one outstanding read, so no master can be granted by two slaves in the same cycle.
- Outputs:
  - `SRIdx[s]` = g in ADDR or DATA, else `NUM_M`.
  - `MRIdx[m]` = s while m is busy, else `NUM_S+1`.
- Non-last R beats and R beats without `RREADY_M` leave the state unchanged.

## Timing
- All outputs are registered.
- Reset values: `SRIdx` = `NUM_M`, `MRIdx` = `NUM_S+1`, all FSMs in IDLE, all busy flags 0, all `rr_ptr` 0.
- Grant latency: `ARVALID_M` seen high at edge k makes the indices valid after edge k. The earliest AR handshake is in cycle k+1.
- Back-to-back use of one slave:
  - The RLAST handshake at edge n returns the FSM to IDLE.
  - The next grant to that slave occurs at edge n+1 at the earliest, a one-cycle bubble.
  - The released master may be re-granted at edge n+1.
- Simultaneous requests to one slave: only one grant; the others stay pending with ARVALID held.
- Requests to different slaves are granted in the same cycle.
- `ARVALID_M` dropping in ADDR violates the AXI protocol. The FSM stays in ADDR; no recovery is required.
- `ARESET` mid-transaction: every FSM returns to IDLE and all outputs take their reset values at that edge. No abort is signalled to any master or slave.

## Structure
- The shared package `axi_pkg` holds:
  - the slave base/limit address constants (used by this block and by the read/write muxes);
  - the `rd_state_e` enum {IDLE, ADDR, DATA};
  - the default/dummy index localparams.
- Sub-module `axi_addr_decoder`: combinational ARADDR → slave index, instantiated once per master. The write-side arbiter reuses it.

## Test plan
- M1 reads 0x0001_0040, `ARREADY_S[1]` the next cycle, 4 beats with RLAST on beat 4:
  - `SRIdx[1]`=1 and `MRIdx[1]`=1 from the cycle after ARVALID;
  - both indices return to 3 and 7 respectively the cycle after the RLAST handshake.
- M0 and M1 request 0x0002_0000 in the same cycle, after reset:
  - M0 is granted first;
  - after M0's RLAST, one idle cycle, then M1 is granted.
  - Repeat with both requesting again: M1 is not skipped, and the order alternates.
- M0 → S0 and M2 → S5 in the same cycle: both are granted at the same edge with independent indices.
- M2 reads 0x3000_0000: routed to the default slave, so `SRIdx[6]`=2 and `MRIdx[2]`=6.
- RLAST asserted with `RREADY_M` low for 3 cycles: the grant is held, and it is released one cycle after `RREADY_M` rises.
- `ARESET` pulsed during the DATA phase of M0 → S2: the next edge gives `SRIdx` all 3, `MRIdx` all 7, and round-robin restarts at M0.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared AXI bridge definitions: slave address map, read-side FSM states
// and the default/dummy routing indices used by the arbiters and muxes.
package axi_pkg;

   localparam int AXI_NUM_M     = 3;
   localparam int AXI_NUM_S     = 6;
   localparam int AXI_MIDX_BITS = 2;
   localparam int AXI_SIDX_BITS = 3;

   // Dummy master never drives valid; default slave answers decode errors;
   // dummy slave is never ready.
   localparam logic [AXI_MIDX_BITS-1:0] AXI_DUMMY_M   = AXI_MIDX_BITS'(AXI_NUM_M);
   localparam logic [AXI_SIDX_BITS-1:0] AXI_DEFAULT_S = AXI_SIDX_BITS'(AXI_NUM_S);
   localparam logic [AXI_SIDX_BITS-1:0] AXI_DUMMY_S   = AXI_SIDX_BITS'(AXI_NUM_S + 1);

   // Slave windows, inclusive limits.
   localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
   localparam logic [31:0] ROM_LIMIT = 32'h0000_3FFF;
   localparam logic [31:0] IM_BASE   = 32'h0001_0000;
   localparam logic [31:0] IM_LIMIT  = 32'h0001_FFFF;
   localparam logic [31:0] DM_BASE   = 32'h0002_0000;
   localparam logic [31:0] DM_LIMIT  = 32'h0002_FFFF;
   localparam logic [31:0] DMA_BASE  = 32'h1002_0000;
   localparam logic [31:0] DMA_LIMIT = 32'h1002_0400;
   localparam logic [31:0] WDT_BASE  = 32'h1001_0000;
   localparam logic [31:0] WDT_LIMIT = 32'h1001_03FF;
   localparam logic [31:0] DRAM_BASE  = 32'h2000_0000;
   localparam logic [31:0] DRAM_LIMIT = 32'h201F_FFFF;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_state_e;

   function automatic logic in_range(logic [31:0] a, logic [31:0] base, logic [31:0] limit);
      return (a >= base) && (a <= limit);
   endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Read-address/read-data handshake bundle seen by the read arbiter.
interface axi_read_arbiter_if import axi_pkg::*; #(
   parameter int NUM_M     = AXI_NUM_M,
   parameter int NUM_S     = AXI_NUM_S,
   parameter int MIDX_BITS = AXI_MIDX_BITS,
   parameter int SIDX_BITS = AXI_SIDX_BITS
);
   logic [NUM_M-1:0][31:0]          ARADDR_M;
   logic [NUM_M-1:0]                ARVALID_M;
   logic [NUM_S:0]                  ARREADY_S;
   logic [NUM_S:0]                  RVALID_S;
   logic [NUM_S:0]                  RLAST_S;
   logic [NUM_M-1:0]                RREADY_M;
   logic [NUM_S:0][MIDX_BITS-1:0]   SRIdx;
   logic [NUM_M-1:0][SIDX_BITS-1:0] MRIdx;

   // Arbiter side: consumes handshakes, produces routing indices.
   modport slave (
      input  ARADDR_M, ARVALID_M, ARREADY_S, RVALID_S, RLAST_S, RREADY_M,
      output SRIdx, MRIdx
   );

   // Bus side: drives handshakes, observes routing indices.
   modport master (
      output ARADDR_M, ARVALID_M, ARREADY_S, RVALID_S, RLAST_S, RREADY_M,
      input  SRIdx, MRIdx
   );
endinterface

// File: rtl/axi_addr_decoder.sv
// Combinational address -> slave index decode; unmapped goes to default slave.
module axi_addr_decoder import axi_pkg::*; (
   input  logic [31:0]              addr,
   output logic [AXI_SIDX_BITS-1:0] sidx
);

   // Windows do not overlap, so priority order is irrelevant.
   always_comb begin
      sidx = AXI_DEFAULT_S;
      if      (in_range(addr, ROM_BASE,  ROM_LIMIT))  sidx = AXI_SIDX_BITS'(0);
      else if (in_range(addr, IM_BASE,   IM_LIMIT))   sidx = AXI_SIDX_BITS'(1);
      else if (in_range(addr, DM_BASE,   DM_LIMIT))   sidx = AXI_SIDX_BITS'(2);
      else if (in_range(addr, DMA_BASE,  DMA_LIMIT))  sidx = AXI_SIDX_BITS'(3);
      else if (in_range(addr, WDT_BASE,  WDT_LIMIT))  sidx = AXI_SIDX_BITS'(4);
      else if (in_range(addr, DRAM_BASE, DRAM_LIMIT)) sidx = AXI_SIDX_BITS'(5);
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// Per-slave read arbiter: round-robin grant per slave, held until the last
// R beat is accepted. Owns all read-path routing state (SRIdx / MRIdx).
module axi_read_arbiter import axi_pkg::*; #(
   parameter int NUM_M     = AXI_NUM_M,
   parameter int NUM_S     = AXI_NUM_S,
   parameter int MIDX_BITS = AXI_MIDX_BITS,
   parameter int SIDX_BITS = AXI_SIDX_BITS
) (
   input logic               ACLK,
   input logic               ARESET,
   axi_read_arbiter_if.slave bus
);

   localparam logic [MIDX_BITS-1:0] IDLE_M = MIDX_BITS'(NUM_M);
   localparam logic [SIDX_BITS-1:0] IDLE_S = SIDX_BITS'(NUM_S + 1);

   logic [NUM_M-1:0][AXI_SIDX_BITS-1:0] dec;
   logic [NUM_M-1:0]                    busy;
   logic [NUM_S:0]                      gnt_vld, rel;
   logic [NUM_S:0][MIDX_BITS-1:0]       gnt_m, sr_q;
   logic [NUM_M-1:0][SIDX_BITS-1:0]     mr_q;

   for (genvar m = 0; m < NUM_M; m++) begin : g_mst
      axi_addr_decoder u_dec (.addr(bus.ARADDR_M[m]), .sidx(dec[m]));
      assign busy[m] = (mr_q[m] != IDLE_S);
   end

   for (genvar s = 0; s <= NUM_S; s++) begin : g_slv
      rd_state_e            state_q, state_d;
      logic [MIDX_BITS-1:0] rr_ptr, win, sr;
      logic [NUM_M-1:0]     cand;
      logic                 found, ar_hs, rl_hs;

      assign ar_hs = bus.ARVALID_M[sr] && bus.ARREADY_S[s];
      assign rl_hs = bus.RVALID_S[s] && bus.RLAST_S[s] && bus.RREADY_M[sr];

      // Round-robin pick: first idle requester at or after rr_ptr.
      always_comb begin
         int idx;
         idx   = 0;
         found = 1'b0;
         win   = '0;
         for (int m = 0; m < NUM_M; m++)
            cand[m] = bus.ARVALID_M[m] && (dec[m] == AXI_SIDX_BITS'(s)) && !busy[m];
         for (int k = 0; k < NUM_M; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_M;
            if (!found && cand[idx]) begin
               found = 1'b1;
               win   = MIDX_BITS'(idx);
            end
         end
      end

      // Next state: grant, address handshake, last-beat handshake.
      always_comb begin
         state_d = state_q;
         case (state_q)
            IDLE:    if (found) state_d = ADDR;
            ADDR:    if (ar_hs) state_d = DATA;
            DATA:    if (rl_hs) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      assign gnt_vld[s] = (state_q == IDLE) && found;
      assign gnt_m[s]   = win;
      assign rel[s]     = (state_q == DATA) && rl_hs;
      assign sr_q[s]    = sr;

      // State, routed master and fairness pointer.
      always_ff @(posedge ACLK) begin
         if (ARESET) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
            sr      <= IDLE_M;
         end else begin
            state_q <= state_d;
            if (gnt_vld[s]) begin
               sr     <= win;
               rr_ptr <= (win == MIDX_BITS'(NUM_M - 1)) ? '0 : win + 1'b1;
            end else if (rel[s]) begin
               sr <= IDLE_M;
            end
         end
      end
   end

   // Per-master route doubles as the busy flag; a master is never granted
   // and released on the same edge, so the two updates cannot collide.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         mr_q <= {NUM_M{IDLE_S}};
      end else begin
         for (int m = 0; m < NUM_M; m++) begin
            for (int s = 0; s <= NUM_S; s++) begin
               if (rel[s] && sr_q[s] == MIDX_BITS'(m))     mr_q[m] <= IDLE_S;
               if (gnt_vld[s] && gnt_m[s] == MIDX_BITS'(m)) mr_q[m] <= SIDX_BITS'(s);
            end
         end
      end
   end

   assign bus.SRIdx = sr_q;
   assign bus.MRIdx = mr_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed scenarios then random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_axi_read_arbiter;

   localparam int NM = 3;
   localparam int NS = 6;
   localparam int NA = 12;

   logic ACLK = 1'b0;
   logic ARESET = 1'b1;
   always #5 ACLK = ~ACLK;

   axi_read_arbiter_if #(.NUM_M(NM), .NUM_S(NS), .MIDX_BITS(2), .SIDX_BITS(3)) bus ();

   axi_read_arbiter #(.NUM_M(NM), .NUM_S(NS), .MIDX_BITS(2), .SIDX_BITS(3)) dut (
      .ACLK  (ACLK),
      .ARESET(ARESET),
      .bus   (bus.slave)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: owner of each slave (-1 free), its phase
   // (1 waiting for AR, 2 receiving data), fairness pointer, and the
   // slave each master is currently reading from (-1 none).
   int own[NS+1];
   int ph[NS+1];
   int ptr[NS+1];
   int mslv[NM];
   bit req[NM];

   logic [31:0] addr_tab[NA] = '{
      32'h0000_0000, 32'h0000_3FFF, 32'h0000_4000, 32'h0001_0040,
      32'h0002_FFFC, 32'h1002_0400, 32'h1002_0404, 32'h1001_03FF,
      32'h2000_0000, 32'h201F_FFFF, 32'h2020_0000, 32'h3000_0000
   };

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int dec_ref(logic [31:0] a);
      if (a <= 32'h0000_3FFF) return 0;
      if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 1;
      if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF) return 2;
      if (a >= 32'h1002_0000 && a <= 32'h1002_0400) return 3;
      if (a >= 32'h1001_0000 && a <= 32'h1001_03FF) return 4;
      if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF) return 5;
      return NS;
   endfunction

   task automatic model_reset();
      for (int s = 0; s <= NS; s++) begin own[s] = -1; ph[s] = 0; ptr[s] = 0; end
      for (int m = 0; m < NM; m++) mslv[m] = -1;
   endtask

   // Advance the model by one edge using the inputs currently applied.
   task automatic model_step();
      int nown[NS+1];
      int nph[NS+1];
      int nptr[NS+1];
      int nmslv[NM];
      int c;
      if (ARESET) begin
         model_reset();
         return;
      end
      nown = own; nph = ph; nptr = ptr; nmslv = mslv;
      for (int s = 0; s <= NS; s++) begin
         if (own[s] >= 0) begin
            c = own[s];
            if (ph[s] == 1 && bus.ARVALID_M[c] && bus.ARREADY_S[s]) nph[s] = 2;
            else if (ph[s] == 2 && bus.RVALID_S[s] && bus.RLAST_S[s] && bus.RREADY_M[c]) begin
               nown[s] = -1; nph[s] = 0; nmslv[c] = -1;
            end
         end else begin
            for (int k = 0; k < NM; k++) begin
               c = (ptr[s] + k) % NM;
               if (bus.ARVALID_M[c] && dec_ref(bus.ARADDR_M[c]) == s && mslv[c] < 0) begin
                  nown[s] = c; nph[s] = 1; nmslv[c] = s; nptr[s] = (c + 1) % NM;
                  break;
               end
            end
         end
      end
      own = nown; ph = nph; ptr = nptr; mslv = nmslv;
   endtask

   function automatic logic [31:0] exp_sr();
      logic [31:0] v = '0;
      for (int s = 0; s <= NS; s++) v[s*2 +: 2] = (own[s] < 0) ? 2'd3 : 2'(own[s]);
      return v;
   endfunction

   function automatic logic [31:0] exp_mr();
      logic [31:0] v = '0;
      for (int m = 0; m < NM; m++) v[m*3 +: 3] = (mslv[m] < 0) ? 3'd7 : 3'(mslv[m]);
      return v;
   endfunction

   task automatic step();
      model_step();
      @(posedge ACLK);
      #1;
      chk("sr_idx", 32'(bus.SRIdx), exp_sr());
      chk("mr_idx", 32'(bus.MRIdx), exp_mr());
   endtask

   task automatic clr();
      bus.ARADDR_M = '0; bus.ARVALID_M = '0; bus.ARREADY_S = '0;
      bus.RVALID_S = '0; bus.RLAST_S = '0; bus.RREADY_M = '0;
   endtask

   // Address handshake, then a single last beat.
   task automatic serve(int s, int m);
      bus.ARREADY_S[s] = 1'b1;
      step();
      bus.ARREADY_S[s] = 1'b0;
      bus.ARVALID_M[m] = 1'b0;
      bus.RVALID_S[s] = 1'b1; bus.RLAST_S[s] = 1'b1; bus.RREADY_M[m] = 1'b1;
      step();
      bus.RVALID_S[s] = 1'b0; bus.RLAST_S[s] = 1'b0; bus.RREADY_M[m] = 1'b0;
   endtask

   initial begin
      clr();
      model_reset();
      ARESET = 1'b1;
      step();
      step();
      chk("rst_sr", 32'(bus.SRIdx), 32'h3FFF);
      chk("rst_mr", 32'(bus.MRIdx), 32'h1FF);
      ARESET = 1'b0;

      // M1 four-beat read from IM.
      bus.ARADDR_M[1] = 32'h0001_0040; bus.ARVALID_M[1] = 1'b1;
      step();
      chk("m1_sr1", 32'(bus.SRIdx[1]), 32'd1);
      chk("m1_mr1", 32'(bus.MRIdx[1]), 32'd1);
      bus.ARREADY_S[1] = 1'b1;
      step();
      bus.ARREADY_S[1] = 1'b0; bus.ARVALID_M[1] = 1'b0;
      bus.RVALID_S[1] = 1'b1; bus.RREADY_M[1] = 1'b1;
      repeat (3) step();
      chk("m1_beats", 32'(bus.SRIdx[1]), 32'd1);
      bus.RLAST_S[1] = 1'b1;
      step();
      chk("m1_rel_sr", 32'(bus.SRIdx[1]), 32'd3);
      chk("m1_rel_mr", 32'(bus.MRIdx[1]), 32'd7);
      clr();

      // M0 and M1 contend for DM, two rounds.
      for (int r = 0; r < 2; r++) begin
         bus.ARADDR_M[0] = 32'h0002_0000; bus.ARADDR_M[1] = 32'h0002_0000;
         bus.ARVALID_M[0] = 1'b1; bus.ARVALID_M[1] = 1'b1;
         step();
         chk("rr_first", 32'(bus.SRIdx[2]), 32'd0);
         serve(2, 0);
         chk("rr_bubble", 32'(bus.SRIdx[2]), 32'd3);
         step();
         chk("rr_second", 32'(bus.SRIdx[2]), 32'd1);
         serve(2, 1);
      end
      clr();

      // Independent slaves granted on the same edge.
      bus.ARADDR_M[0] = 32'h0000_0100; bus.ARADDR_M[2] = 32'h2000_0000;
      bus.ARVALID_M[0] = 1'b1; bus.ARVALID_M[2] = 1'b1;
      step();
      chk("par_sr0", 32'(bus.SRIdx[0]), 32'd0);
      chk("par_sr5", 32'(bus.SRIdx[5]), 32'd2);
      chk("par_mr2", 32'(bus.MRIdx[2]), 32'd5);
      serve(0, 0);
      serve(5, 2);
      clr();

      // Unmapped address to default slave.
      bus.ARADDR_M[2] = 32'h3000_0000; bus.ARVALID_M[2] = 1'b1;
      step();
      chk("def_sr6", 32'(bus.SRIdx[6]), 32'd2);
      chk("def_mr2", 32'(bus.MRIdx[2]), 32'd6);
      serve(6, 2);
      clr();

      // Last beat stalled by RREADY low.
      bus.ARADDR_M[1] = 32'h1001_0000; bus.ARVALID_M[1] = 1'b1;
      step();
      bus.ARREADY_S[4] = 1'b1;
      step();
      bus.ARREADY_S[4] = 1'b0; bus.ARVALID_M[1] = 1'b0;
      bus.RVALID_S[4] = 1'b1; bus.RLAST_S[4] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold", 32'(bus.SRIdx[4]), 32'd1);
      end
      bus.RREADY_M[1] = 1'b1;
      step();
      chk("stall_rel_sr", 32'(bus.SRIdx[4]), 32'd3);
      chk("stall_rel_mr", 32'(bus.MRIdx[1]), 32'd7);
      clr();

      // Reset during DATA of M0 -> DM; fairness pointer restarts at M0.
      bus.ARADDR_M[0] = 32'h0002_0010; bus.ARVALID_M[0] = 1'b1;
      step();
      bus.ARREADY_S[2] = 1'b1;
      step();
      clr();
      ARESET = 1'b1;
      step();
      chk("mid_rst_sr", 32'(bus.SRIdx), 32'h3FFF);
      chk("mid_rst_mr", 32'(bus.MRIdx), 32'h1FF);
      ARESET = 1'b0;
      bus.ARADDR_M[0] = 32'h0002_0000; bus.ARADDR_M[1] = 32'h0002_0000;
      bus.ARVALID_M[0] = 1'b1; bus.ARVALID_M[1] = 1'b1;
      step();
      chk("post_rst_rr", 32'(bus.SRIdx[2]), 32'd0);
      serve(2, 0);
      step();
      serve(2, 1);
      clr();

      // Random traffic; masters hold ARVALID until their AR handshake.
      for (int m = 0; m < NM; m++) req[m] = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int m = 0; m < NM; m++) begin
            if (mslv[m] >= 0 && ph[mslv[m]] == 2) begin
               bus.ARVALID_M[m] = 1'b0;
               req[m] = 1'b0;
            end else if (mslv[m] < 0 && !req[m] && $urandom_range(0, 2) == 0) begin
               req[m] = 1'b1;
               bus.ARADDR_M[m] = addr_tab[$urandom_range(0, NA - 1)];
               bus.ARVALID_M[m] = 1'b1;
            end
            bus.RREADY_M[m] = 1'($urandom_range(0, 1));
         end
         for (int s = 0; s <= NS; s++) begin
            bus.ARREADY_S[s] = 1'($urandom_range(0, 1));
            bus.RVALID_S[s]  = 1'($urandom_range(0, 1));
            bus.RLAST_S[s]   = ($urandom_range(0, 2) == 0);
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
